// File: rtl/note_sprite_blitter.sv
// note_sprite_blitter: walks a SPR_W x SPR_H 1-bit sprite ROM in raster order,
// absorbs the ROM's one-cycle read latency and writes set pixels into a 1-bpp
// framebuffer at (x0, y0), clipping anything off the right or bottom edge.
// Optional build macro NOTE_BLIT_ERASE_EN adds an 'erase' input; an erase blit
// writes 0 instead of 1 at every set sprite pixel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready, waiting for start
// S_SCAN  | issuing one sprite ROM address per non-stalled cycle
// S_DRAIN | all addresses issued, waiting for the pipeline to empty
// S_DONE  | one-cycle completion pulse
module note_sprite_blitter #(
    parameter int SPR_W  = 20,
    parameter int SPR_H  = 30,
    parameter int ROM_AW = 10,
    parameter int FB_W   = 640,
    parameter int FB_H   = 480,
    parameter int FB_AW  = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        x0,
    input  logic [9:0]        y0,
`ifdef NOTE_BLIT_ERASE_EN
    input  logic              erase,
`endif
    output logic              ready,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic              rom_pixel,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic              fb_data,
    input  logic              fb_ready
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;

    logic [9:0]        r_x0;
    logic [9:0]        r_y0;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [ROM_AW-1:0] r_addr;

    logic              r_s1_valid;
    logic [CW-1:0]     r_s1_col;
    logic [RW-1:0]     r_s1_row;
    logic [ROM_AW-1:0] r_s1_addr;

    logic              r_fb_we;
    logic [FB_AW-1:0]  r_fb_addr;
    logic              r_fb_data;

    logic              w_stall;
    logic              w_accept;
    logic              w_issue;
    logic              w_last;
    logic [10:0]       w_x;
    logic [10:0]       w_y;
    logic              w_in_fb;
    logic [FB_AW-1:0]  w_fb_addr;
    logic              w_pix_data;

    assign w_stall  = r_fb_we & ~fb_ready;
    assign w_accept = (r_state == S_IDLE) & start;
    assign w_issue  = (r_state == S_SCAN) & ~w_stall;
    assign w_last   = (r_col == CW'(SPR_W - 1)) && (r_row == RW'(SPR_H - 1));

    // During a stall the ROM must keep presenting stage 1's pixel.
    assign rom_addr = w_stall ? r_s1_addr : r_addr;

    // 11-bit sums so that x0+col / y0+row never wrap before the clip test.
    assign w_x       = {1'b0, r_x0} + 11'(r_s1_col);
    assign w_y       = {1'b0, r_y0} + 11'(r_s1_row);
    assign w_in_fb   = (w_x < 11'(FB_W)) && (w_y < 11'(FB_H));
    assign w_fb_addr = FB_AW'(w_y) * FB_AW'(FB_W) + FB_AW'(w_x);

`ifdef NOTE_BLIT_ERASE_EN
    logic r_erase;

    // Erase flag is captured with the coordinates on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_erase <= 1'b0;
        else if (w_accept) r_erase <= erase;
    end

    assign w_pix_data = ~r_erase;
`else
    assign w_pix_data = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_next = S_SCAN;
            end
            S_SCAN: begin
                if (w_issue && w_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_s1_valid && !w_stall) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Origin latch and raster counters, col fastest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x0   <= '0;
            r_y0   <= '0;
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (w_accept) begin
            r_x0   <= x0;
            r_y0   <= y0;
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (w_issue) begin
            if (r_col == CW'(SPR_W - 1)) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
            r_addr <= r_addr + ROM_AW'(1);
        end
    end

    // Stage 1: tracks the pixel whose ROM read is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_s1_addr  <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_issue;
            r_s1_col   <= r_col;
            r_s1_row   <= r_row;
            r_s1_addr  <= r_addr;
        end
    end

    // Output stage: write only set, on-screen pixels; hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= 1'b0;
        end else if (!w_stall) begin
            r_fb_we   <= r_s1_valid & rom_pixel & w_in_fb;
            r_fb_addr <= w_fb_addr;
            r_fb_data <= w_pix_data;
        end
    end

    assign fb_we   = r_fb_we;
    assign fb_addr = r_fb_addr;
    assign fb_data = r_fb_data;

endmodule

// File: tb/tb_note_sprite_blitter.sv
// Testbench for note_sprite_blitter: registered ROM model, scoreboard of
// expected framebuffer writes (address, data, completion cycle).
module tb_note_sprite_blitter;

    localparam int SPR_W  = 20;
    localparam int SPR_H  = 30;
    localparam int ROM_AW = 10;
    localparam int FB_W   = 640;
    localparam int FB_H   = 480;
    localparam int FB_AW  = 19;
    localparam int NPIX   = SPR_W * SPR_H;

    typedef struct {
        int addr;
        bit data;
        int t;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic [9:0]        x0;
    logic [9:0]        y0;
`ifdef NOTE_BLIT_ERASE_EN
    logic              erase;
`endif
    logic              ready;
    logic              done;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_pixel;
    logic              fb_we;
    logic [FB_AW-1:0]  fb_addr;
    logic              fb_data;
    logic              fb_ready;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   rom_mode = 0;
    exp_t exp_q[$];

    note_sprite_blitter #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_AW(ROM_AW),
        .FB_W(FB_W), .FB_H(FB_H), .FB_AW(FB_AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .x0(x0),
        .y0(y0),
`ifdef NOTE_BLIT_ERASE_EN
        .erase(erase),
`endif
        .ready(ready),
        .done(done),
        .rom_addr(rom_addr),
        .rom_pixel(rom_pixel),
        .fb_we(fb_we),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .fb_ready(fb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite content: mode 0 = only (col=1,row=7) set, mode 1 = all ones.
    function automatic bit rom_bit(int a);
        if (rom_mode == 1) return 1'b1;
        return (a == 7 * SPR_W + 1);
    endfunction

    always @(posedge clk) rom_pixel <= rom_bit(int'(rom_addr));

    // Scoreboard fill: pixel k completes at cycle k+2, plus stall_len from pixel stall_k on.
    task automatic push_expected(int x, int y, bit data, int stall_k, int stall_len);
        exp_t e;
        int   row;
        int   col;
        exp_q.delete();
        for (int k = 0; k < NPIX; k++) begin
            row = k / SPR_W;
            col = k % SPR_W;
            if (rom_bit(k) && (x + col < FB_W) && (y + row < FB_H)) begin
                e.addr = (y + row) * FB_W + (x + col);
                e.data = data;
                e.t    = k + 2 + ((stall_k >= 0 && k >= stall_k) ? stall_len : 0);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(int x, int y);
        @(negedge clk);
        x0    = 10'(x);
        y0    = 10'(y);
        start = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        x0       = '0;
        y0       = '0;
        fb_ready = 1'b1;
`ifdef NOTE_BLIT_ERASE_EN
        erase    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status ready=%b done=%b required ready=1 done=0", ready, done);
        end
        n_checks++;
        if (fb_we !== 1'b0 || fb_addr !== '0 || fb_data !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fb fb_we=%b fb_addr=%0d fb_data=%b required 0/0/0", fb_we, fb_addr, fb_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_pixel();
        exp_t e;
        int   done_t = -1;
        int   nwr = 0;
        rom_mode = 0;
        push_expected(100, 50, 1'b1, -1, 0);
        pulse_start(100, 50);
        for (int t = 0; t < 800 && done_t < 0; t++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (t < NPIX) begin
                n_checks++;
                if (rom_addr !== ROM_AW'(t)) begin
                    n_fail++;
                    $display("FAIL single_rom_addr t=%0d got %0d required %0d", t, rom_addr, t);
                end
            end
            if (fb_we && fb_ready) begin
                nwr++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL single_extra_write t=%0d addr=%0d required none", t, fb_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(fb_addr) !== e.addr || fb_data !== e.data || t != e.t) begin
                        n_fail++;
                        $display("FAIL single_write got addr=%0d data=%b t=%0d required addr=%0d data=%b t=%0d",
                                 fb_addr, fb_data, t, e.addr, e.data, e.t);
                    end
                end
            end
            if (done) done_t = t;
        end
        n_checks++;
        if (done_t != 602) begin
            n_fail++;
            $display("FAIL single_done_cycle got %0d required 602", done_t);
        end
        n_checks++;
        if (nwr != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_write_count got %0d writes, %0d missing, required 1/0", nwr, exp_q.size());
        end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after_done ready=%b done=%b required 1/0", ready, done);
        end
    endtask

    task automatic test_clipping(bit erase_val);
        exp_t e;
        int   done_t = -1;
        int   nwr = 0;
        int   first_a = -1;
        int   last_a = -1;
        rom_mode = 1;
        push_expected(630, 470, ~erase_val, -1, 0);
`ifdef NOTE_BLIT_ERASE_EN
        erase = erase_val;
`endif
        pulse_start(630, 470);
        for (int t = 0; t < 800 && done_t < 0; t++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (fb_we && fb_ready) begin
                nwr++;
                if (first_a < 0) first_a = int'(fb_addr);
                last_a = int'(fb_addr);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL clip_extra_write t=%0d addr=%0d required none", t, fb_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(fb_addr) !== e.addr || fb_data !== e.data || t != e.t) begin
                        n_fail++;
                        $display("FAIL clip_write got addr=%0d data=%b t=%0d required addr=%0d data=%b t=%0d",
                                 fb_addr, fb_data, t, e.addr, e.data, e.t);
                    end
                end
            end
            if (done) done_t = t;
        end
`ifdef NOTE_BLIT_ERASE_EN
        erase = 1'b0;
`endif
        n_checks++;
        if (nwr != 100 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL clip_count got %0d writes, %0d missing, required 100/0", nwr, exp_q.size());
        end
        n_checks++;
        if (first_a != 301430 || last_a != 307199) begin
            n_fail++;
            $display("FAIL clip_bounds first=%0d last=%0d required 301430/307199", first_a, last_a);
        end
        n_checks++;
        if (done_t != 602) begin
            n_fail++;
            $display("FAIL clip_done_cycle got %0d required 602", done_t);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        exp_t             e;
        int               done_t = -1;
        int               nwr = 0;
        int               left = 0;
        bit               once = 0;
        logic [FB_AW-1:0] held_addr = '0;
        rom_mode = 1;
        push_expected(0, 0, 1'b1, 4, 3);
        pulse_start(0, 0);
        for (int t = 0; t < 900 && done_t < 0; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (!fb_ready && left == 0) fb_ready = 1'b1;
            if (left > 0) begin
                #1;
                left--;
                n_checks++;
                if (fb_we !== 1'b1 || fb_addr !== held_addr || fb_data !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_hold t=%0d we=%b addr=%0d data=%b required 1/%0d/1",
                             t, fb_we, fb_addr, fb_data, held_addr);
                end
            end else if (!once && fb_we && nwr == 4) begin
                once      = 1;
                left      = 2;
                held_addr = fb_addr;
                fb_ready  = 1'b0;
                #1;
            end else begin
                #1;
            end
            if (!fb_ready) begin
                n_checks++;
                if (rom_addr !== ROM_AW'(5)) begin
                    n_fail++;
                    $display("FAIL stall_rom_addr t=%0d got %0d required 5", t, rom_addr);
                end
            end
            if (fb_we && fb_ready) begin
                nwr++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stall_extra_write t=%0d addr=%0d required none", t, fb_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(fb_addr) !== e.addr || fb_data !== e.data || t != e.t) begin
                        n_fail++;
                        $display("FAIL stall_write got addr=%0d data=%b t=%0d required addr=%0d data=%b t=%0d",
                                 fb_addr, fb_data, t, e.addr, e.data, e.t);
                    end
                end
            end
            if (done) done_t = t;
        end
        fb_ready = 1'b1;
        n_checks++;
        if (nwr != NPIX || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_count got %0d writes, %0d missing, required %0d/0", nwr, exp_q.size(), NPIX);
        end
        n_checks++;
        if (done_t != 605) begin
            n_fail++;
            $display("FAIL stall_done_cycle got %0d required 605", done_t);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   done_t = -1;
        int   n_done = 0;
        int   nwr = 0;
        rom_mode = 1;
        push_expected(200, 100, 1'b1, -1, 0);
        pulse_start(200, 100);
        for (int t = 0; t < 700; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t == 10 || t == 300) begin
                start = 1'b1;
                x0    = 10'd5;
                y0    = 10'd5;
            end
            #1;
            if (done_t < 0 && !done) begin
                n_checks++;
                if (ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_ready t=%0d got %b required 0", t, ready);
                end
            end
            if (fb_we && fb_ready) begin
                nwr++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL busy_extra_write t=%0d addr=%0d required none", t, fb_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(fb_addr) !== e.addr || fb_data !== e.data || t != e.t) begin
                        n_fail++;
                        $display("FAIL busy_write got addr=%0d data=%b t=%0d required addr=%0d data=%b t=%0d",
                                 fb_addr, fb_data, t, e.addr, e.data, e.t);
                    end
                end
            end
            if (done) begin
                n_done++;
                if (done_t < 0) done_t = t;
            end
        end
        start = 1'b0;
        n_checks++;
        if (n_done != 1 || done_t != 602) begin
            n_fail++;
            $display("FAIL busy_done got %0d pulses first at %0d required 1 at 602", n_done, done_t);
        end
        n_checks++;
        if (nwr != NPIX || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL busy_count got %0d writes, %0d missing, required %0d/0", nwr, exp_q.size(), NPIX);
        end
    endtask

    task automatic test_reset_mid_blit();
        int nwr = 0;
        int n_done = 0;
        rom_mode = 1;
        exp_q.delete();
        pulse_start(0, 0);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        n_checks++;
        if (fb_we !== 1'b1 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_before we=%b ready=%b required 1/0", fb_we, ready);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (fb_we !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async we=%b ready=%b done=%b required 0/1/0", fb_we, ready, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 700; t++) begin
            @(negedge clk);
            #1;
            if (fb_we) nwr++;
            if (done) n_done++;
        end
        n_checks++;
        if (nwr != 0 || n_done != 0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_after writes=%0d done=%0d ready=%b required 0/0/1", nwr, n_done, ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_clipping(1'b0);
        test_stall();
        test_start_ignored();
`ifdef NOTE_BLIT_ERASE_EN
        test_clipping(1'b1);
`endif
        test_reset_mid_blit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_sprite_blitter.md
Name: note_sprite_blitter

Overview:
- Reader/consumer side of the 1-bit note sprite ROMs: walks a SPR_W x SPR_H sprite, issues ROM addresses, absorbs the ROM's 1-cycle registered read latency, and writes set pixels into the 1-bpp staff framebuffer at a requested (x0, y0).
- Sits between the score/note scheduler (start/ready handshake) and the framebuffer write arbiter (fb_we/fb_ready handshake).
- Clips pixels that fall outside the framebuffer.

Parameters:
- SPR_W, 20, sprite width in pixels.
- SPR_H, 30, sprite height in pixels.
- ROM_AW, 10, ROM address width; must satisfy 2^ROM_AW >= SPR_W*SPR_H.
- FB_W, 640, framebuffer width in pixels.
- FB_H, 480, framebuffer height in pixels.
- FB_AW, 19, framebuffer address width; must satisfy 2^FB_AW >= FB_W*FB_H.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a blit; accepted only when ready=1.
- x0  in  10  sprite top-left column; latched on accept.
- y0  in  10  sprite top-left row; latched on accept.
- ready  out  1  idle, can accept start.
- done  out  1  one-cycle pulse when the blit has fully completed.
- rom_addr  out  ROM_AW  sprite ROM address, row*SPR_W+col; combinational.
- rom_pixel  in  1  ROM data, valid the cycle after rom_addr is presented.
- fb_we  out  1  framebuffer write valid; registered.
- fb_addr  out  FB_AW  (y0+row)*FB_W+(x0+col); registered.
- fb_data  out  1  pixel value to write; registered.
- fb_ready  in  1  arbiter accepts the write this cycle.

Behaviour:
- Reset (async): state=IDLE, ready=1, done=0, fb_we=0, fb_addr=0, fb_data=0, all counters and pipeline valids cleared. Reset mid-blit abandons the blit; no further writes are issued.
- States:
  - IDLE: ready=1. On start=1, latch x0/y0, col=row=0, go to SCAN. start while not in IDLE is ignored.
  - SCAN: one sprite address per non-stalled cycle, raster order, col fastest. After issuing col=SPR_W-1, row=SPR_H-1, go to DRAIN.
  - DRAIN: wait until stage-1 and the output stage are empty and no write is pending, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Pipeline:
  - Stage 1 registers {valid, col, row, issued address}, alongside the ROM read.
  - Output stage combines stage 1 with rom_pixel and registers fb_we/fb_addr/fb_data.
- Write condition: fb_we=1 only if rom_pixel=1 and x0+col<FB_W and y0+row<FB_H. Coordinate sums are computed at 11 bits so they never wrap. Clear or clipped pixels produce no write and no stall.
- stall = fb_we & ~fb_ready:
  - While stalled, all state (counters, stage 1, output stage) freezes, and rom_addr is driven from stage 1's issued address so rom_pixel remains valid for stage 1.
  - When not stalled, rom_addr is driven from the counters.
- Handshake: fb_we/fb_addr/fb_data hold stable while fb_we=1 and fb_ready=0. A write completes on the cycle with fb_we=1 and fb_ready=1.
- Timing with fb_ready tied high, start accepted at edge E0:
  - Pixel k is addressed between E_k and E_(k+1).
  - Its write, if any, is visible between E_(k+2) and E_(k+3).
  - done is high between E_(SPR_W*SPR_H+2) and the next edge; ready rises at the same edge done falls.
- Each stall cycle delays all subsequent timing by exactly one cycle.
- fb_data = 1 in the base build.

Optional Feature:
- Macro: NOTE_BLIT_ERASE_EN.
- When defined:
  - Adds input port erase (1 bit), latched on accept.
  - fb_data = ~erase_latched, so an erase blit writes 0 at every set sprite pixel; used to remove a moved note.
  - Write condition, clipping and timing are unchanged.
- When undefined: no erase port; fb_data is constant 1.

Test Plan:
- Full blit, fb_ready=1, x0=100, y0=50, ROM model with only pixel (col=1, row=7) set:
  - Exactly one fb_we pulse, fb_addr=57*640+101=36581, fb_data=1, between E_143 and E_144.
  - done is high between E_602 and E_603.
- All-ones ROM, x0=630, y0=470: clipping.
  - Only col 0-9 / row 0-9 write, i.e. 100 writes.
  - First write fb_addr=470*640+630=301430; last write fb_addr=479*640+639=307199.
- All-ones ROM, fb_ready low 3 cycles on the 5th write:
  - fb_we/fb_addr/fb_data are held stable during the stall.
  - rom_addr equals stage 1's address during the stall.
  - All 600 addresses are written exactly once.
  - done is delayed by 3 cycles versus the unstalled run.
- start pulsed at cycles 10 and 300 of an active blit: both are ignored; exactly one done; ready stays 0 until done.
- reset asserted at cycle 200 of a blit: fb_we=0 and ready=1 immediately (asynchronously), with no further writes and no done.
- With NOTE_BLIT_ERASE_EN defined, erase=1, fb_ready=1: every write carries fb_data=0, with the same addresses and count as the erase=0 run.
